// File: rtl/stream_demux_if.sv
// Purpose : bundles the ingress stream and the N per-channel egress streams of stream_demux.
// Ports   : in_data/in_sel/in_valid/in_ready (ingress), out_data/out_valid/out_ready (egress),
//           err (dropped-beat pulse), cnt (per-channel delivered count, only with STREAM_DEMUX_CNT_EN).
// Modports: master = producer/consumer side (testbench or surrounding logic), slave = the demux itself.
interface stream_demux_if #(
   parameter int WIDTH = 8,
   parameter int N     = 8
`ifdef STREAM_DEMUX_CNT_EN
   , parameter int CNT_W = 16
`endif
);
   localparam int SEL_W = $clog2(N);

   logic [WIDTH-1:0]   in_data;
   logic [SEL_W-1:0]   in_sel;
   logic               in_valid;
   logic               in_ready;
   logic [N*WIDTH-1:0] out_data;
   logic [N-1:0]       out_valid;
   logic [N-1:0]       out_ready;
   logic               err;
`ifdef STREAM_DEMUX_CNT_EN
   logic [N*CNT_W-1:0] cnt;

   modport master (output in_data, in_sel, in_valid, out_ready,
                   input  in_ready, out_data, out_valid, err, cnt);
   modport slave  (input  in_data, in_sel, in_valid, out_ready,
                   output in_ready, out_data, out_valid, err, cnt);
`else
   modport master (output in_data, in_sel, in_valid, out_ready,
                   input  in_ready, out_data, out_valid, err);
   modport slave  (input  in_data, in_sel, in_valid, out_ready,
                   output in_ready, out_data, out_valid, err);
`endif
endinterface

// File: rtl/stream_demux.sv
// Purpose : registered 1-to-N stream demux; each beat is steered by in_sel into a one-entry slot per channel.
// Latency : 1 cycle from accept edge to out_valid/out_data of the selected channel; err is registered too.
// Backpr. : in_ready follows only the selected slot (free = empty or draining); a stalled channel blocks
//           only beats addressed to it; beats with in_sel >= N are always accepted and dropped.
// Ports   : clk, rst (sync, active high), bus (stream_demux_if.slave). The interface instance must be
//           built with the same WIDTH/N (and CNT_W) as this module.
// Option  : STREAM_DEMUX_CNT_EN adds per-channel delivered-beat counters (CNT_W bits, wrapping) on bus.cnt.
module stream_demux #(
   parameter int WIDTH = 8,
   parameter int N     = 8
`ifdef STREAM_DEMUX_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic          clk,
   input  logic          rst,
   stream_demux_if.slave bus
);
   localparam int SEL_W = $clog2(N);
   // One extra bit so the range check stays meaningful when N is a power of two.
   localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

   logic [N-1:0]       valid_q;
   logic [N*WIDTH-1:0] data_q;
   logic               err_q;
   logic [N-1:0]       free;
   logic [N-1:0]       load;
   logic               sel_bad;
   logic               sel_free;

   assign free    = ~valid_q | bus.out_ready;
   assign sel_bad = {1'b0, bus.in_sel} >= N_EXT;

   // Decode in_sel by comparison rather than indexing so an out-of-range select never reads past the vectors.
   always_comb begin
      load     = '0;
      sel_free = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (bus.in_sel == SEL_W'(k)) begin
            sel_free = free[k];
            load[k]  = bus.in_valid & free[k];
         end
      end
   end

   assign bus.in_ready = sel_bad | sel_free;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= bus.in_valid & sel_bad;
         for (int k = 0; k < N; k++) begin
            // A load into a draining slot wins, keeping the channel at full throughput.
            if (load[k]) begin
               valid_q[k]                <= 1'b1;
               data_q[k*WIDTH +: WIDTH]  <= bus.in_data;
            end else if (bus.out_ready[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.err       = err_q;

`ifdef STREAM_DEMUX_CNT_EN
   logic [N*CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (valid_q[k] && bus.out_ready[k]) begin
               cnt_q[k*CNT_W +: CNT_W] <= cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end

   assign bus.cnt = cnt_q;
`endif
endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;
   localparam int WIDTH = 8;
   localparam int N     = 6;
   localparam int CNT_W = 4;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

`ifdef STREAM_DEMUX_CNT_EN
   stream_demux_if #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) bus ();
   stream_demux #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
   stream_demux_if #(.WIDTH(WIDTH), .N(N)) bus ();
   stream_demux #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: one slot per channel, rules applied once per cycle.
   logic       mv   [N];
   logic [7:0] md   [N];
   int         mcnt [N];
   logic       merr;
   logic       last_rdy;

   typedef struct {
      logic       v;
      logic [2:0] sel;
      logic [7:0] d;
      logic [5:0] rdy;
      logic       e_rdy;
      logic [5:0] e_ov;
      logic       e_err;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [5:0] r,
                               input logic er, input logic [5:0] eov, input logic ee);
      tbl.push_back('{v, s, d, r, er, eov, ee});
   endfunction

   task automatic check_outputs();
      logic [5:0] ov;
      for (int k = 0; k < N; k++) ov[k] = mv[k];
      chk("out_valid", bus.out_valid, ov);
      chk("err", bus.err, merr);
      for (int k = 0; k < N; k++)
         if (mv[k]) chk($sformatf("out_data[%0d]", k), bus.out_data[k*WIDTH +: WIDTH], md[k]);
`ifdef STREAM_DEMUX_CNT_EN
      for (int k = 0; k < N; k++)
         chk($sformatf("cnt[%0d]", k), bus.cnt[k*CNT_W +: CNT_W], CNT_W'(mcnt[k]));
`endif
   endtask

   task automatic step(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [5:0] r);
      logic exp_rdy;
      logic acc;
      logic hs;
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_data   = d;
      bus.out_ready = r;
      #1;
      if (s >= 3'd6) exp_rdy = 1'b1;
      else           exp_rdy = !mv[s] || r[s];
      last_rdy = bus.in_ready;
      chk("in_ready", bus.in_ready, exp_rdy);
      acc = v && exp_rdy;
      for (int k = 0; k < N; k++) begin
         hs = mv[k] && r[k];
         if (hs) mcnt[k] = (mcnt[k] + 1) % (1 << CNT_W);
         if (acc && s == 3'(k)) begin
            mv[k] = 1'b1;
            md[k] = d;
         end else if (hs) begin
            mv[k] = 1'b0;
         end
      end
      merr = acc && (s >= 3'd6);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset(input logic v_during);
      bus.in_valid  = v_during;
      bus.in_sel    = 3'd2;
      bus.in_data   = 8'hEE;
      bus.out_ready = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         mv[k] = 1'b0; md[k] = 8'h00; mcnt[k] = 0;
      end
      merr = 1'b0;
      chk("rst_out_valid", bus.out_valid, 6'h00);
      chk("rst_out_data", bus.out_data, 48'h0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef STREAM_DEMUX_CNT_EN
      chk("rst_cnt", bus.cnt, 24'h0);
`endif
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_data = '0; bus.out_ready = '0;
      do_reset(1'b0);
      step(1'b0, 3'd0, 8'h00, 6'h00);

      // Stream 0x11..0x18 over selects 0..7; selects 6 and 7 are out of range for N=6.
      for (int k = 0; k < 8; k++)
         add(1'b1, 3'(k), 8'(8'h11 + k), 6'h3F, 1'b1, (k < 6) ? 6'(1 << k) : 6'h00, k >= 6);
      add(1'b0, 3'd0, 8'h00, 6'h3F, 1'b1, 6'h00, 1'b0);
      // Channel 3 stalled: second beat blocked, channel 5 unaffected, release admits it same cycle.
      add(1'b1, 3'd3, 8'hA1, 6'h37, 1'b1, 6'h08, 1'b0);
      add(1'b1, 3'd3, 8'hA2, 6'h37, 1'b0, 6'h08, 1'b0);
      add(1'b1, 3'd5, 8'hB1, 6'h37, 1'b1, 6'h28, 1'b0);
      add(1'b1, 3'd3, 8'hA2, 6'h3F, 1'b1, 6'h08, 1'b0);
      add(1'b0, 3'd0, 8'h00, 6'h3F, 1'b1, 6'h00, 1'b0);
      // Load and drain on channel 2 in the same cycle.
      add(1'b1, 3'd2, 8'h21, 6'h3F, 1'b1, 6'h04, 1'b0);
      add(1'b1, 3'd2, 8'h22, 6'h3F, 1'b1, 6'h04, 1'b0);
      add(1'b0, 3'd0, 8'h00, 6'h3F, 1'b1, 6'h00, 1'b0);
      // Fill three slots, then a blocked beat and a dropped beat that leaves slots untouched.
      add(1'b1, 3'd0, 8'h30, 6'h00, 1'b1, 6'h01, 1'b0);
      add(1'b1, 3'd1, 8'h31, 6'h00, 1'b1, 6'h03, 1'b0);
      add(1'b1, 3'd4, 8'h34, 6'h00, 1'b1, 6'h13, 1'b0);
      add(1'b1, 3'd0, 8'h40, 6'h00, 1'b0, 6'h13, 1'b0);
      add(1'b1, 3'd7, 8'h77, 6'h00, 1'b1, 6'h13, 1'b1);
      add(1'b0, 3'd2, 8'h00, 6'h00, 1'b1, 6'h13, 1'b0);

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].rdy);
         chk($sformatf("tbl%0d_in_ready", i), last_rdy, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_ov);
         chk($sformatf("tbl%0d_err", i), bus.err, tbl[i].e_err);
      end

      // Reset with three slots full, offering a beat during reset: nothing may survive or land.
      do_reset(1'b1);
      step(1'b0, 3'd2, 8'h00, 6'h00);
      chk("post_rst_no_beat", bus.out_valid, 6'h00);

`ifdef STREAM_DEMUX_CNT_EN
      // 17 handshakes on channel 1 with a 4-bit counter wrap to 1.
      for (int i = 0; i < 17; i++) step(1'b1, 3'd1, 8'(i), 6'h3F);
      step(1'b0, 3'd0, 8'h00, 6'h3F);
      chk("cnt1_wrap", bus.cnt[1*CNT_W +: CNT_W], 4'd1);
      do_reset(1'b0);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            do_reset($urandom_range(0, 1) == 1);
         end else begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                 6'($urandom) | (($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
